// File: rtl/vga_timing_gen.sv
// XGA video timing generator.
// Produces the pixel column/line counters, the sync and blanking flags and the
// line/frame start pulses that the drawing stages consume. The counters and
// every flag are registered together from the same "next" values, so each flag
// always describes the coordinate shown in the same cycle.
// Both totals (active + porches + sync) must not exceed 4096, and every
// parameter must be at least 1.

module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clk_in,
    input  logic        rst,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries, pre-sized to the counter width.
    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcount_next;
    logic [11:0] vcount_next;
    logic        h_wrap;
    logic        v_wrap;

    // Next-coordinate computation: the line counter only moves when the pixel counter wraps.
    always_comb begin
        h_wrap      = (hcount_out == H_LAST);
        v_wrap      = (vcount_out == V_LAST);
        hcount_next = h_wrap ? 12'd0 : hcount_out + 12'd1;
        vcount_next = vcount_out;
        if (h_wrap) begin
            vcount_next = v_wrap ? 12'd0 : vcount_out + 12'd1;
        end
    end

    // Register counters and flags together; flags are decoded from the next
    // values so they line up with the counters they describe. Pulses are only
    // raised by an actual wrap, so the reset state (0,0) is never flagged.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcount_out  <= 12'd0;
            vcount_out  <= 12'd0;
            hsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vsync_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            hcount_out  <= hcount_next;
            vcount_out  <= vcount_next;
            hblnk_out   <= (hcount_next >= H_BLNK_START);
            hsync_out   <= (hcount_next >= H_SYNC_START) && (hcount_next < H_SYNC_END);
            vblnk_out   <= (vcount_next >= V_BLNK_START);
            vsync_out   <= (vcount_next >= V_SYNC_START) && (vcount_next < V_SYNC_END);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default XGA instance and a short-parameter
// instance run side by side from one clock and reset. Expected outputs come
// from an arithmetic model indexed by the number of clocks since reset release.

module tb_vga_timing_gen;

    logic clk_in;
    logic rst;

    logic [11:0] d_hcount, d_vcount, s_hcount, s_vcount;
    logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_line_start, d_frame_start;
    logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_line_start, s_frame_start;
    logic [15:0] d_frame_count, s_frame_count;

    logic [45:0] d_obs;
    logic [45:0] s_obs;
    assign d_obs = {d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk,
                    d_line_start, d_frame_start, d_frame_count};
    assign s_obs = {s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk,
                    s_line_start, s_frame_start, s_frame_count};

    int     tests;
    int     fails;
    longint t;      // clocks since reset release

    vga_timing_gen dut_d (
        .clk_in      (clk_in),
        .rst         (rst),
        .hcount_out  (d_hcount),
        .hsync_out   (d_hsync),
        .hblnk_out   (d_hblnk),
        .vcount_out  (d_vcount),
        .vsync_out   (d_vsync),
        .vblnk_out   (d_vblnk),
        .line_start  (d_line_start),
        .frame_start (d_frame_start),
        .frame_count (d_frame_count)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .clk_in      (clk_in),
        .rst         (rst),
        .hcount_out  (s_hcount),
        .hsync_out   (s_hsync),
        .hblnk_out   (s_hblnk),
        .vcount_out  (s_vcount),
        .vsync_out   (s_vsync),
        .vblnk_out   (s_vblnk),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .frame_count (s_frame_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: the picture is a raster of ht x vt clocks; position is just
    // the elapsed clock count folded into that raster.
    function automatic logic [45:0] model(longint tc, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
        longint ht  = longint'(ha + hf + hs + hb);
        longint vt  = longint'(va + vf + vs + vb);
        longint h   = tc % ht;
        longint v   = (tc / ht) % vt;
        longint f   = (tc / (ht * vt)) % 65536;
        logic   hsy = (h >= ha + hf) && (h < ha + hf + hs);
        logic   hbl = (h >= ha);
        logic   vsy = (v >= va + vf) && (v < va + vf + vs);
        logic   vbl = (v >= va);
        logic   ls  = (tc > 0) && (h == 0);
        logic   fs  = ls && (v == 0);
        return {12'(h), 12'(v), hsy, hbl, vsy, vbl, ls, fs, 16'(f)};
    endfunction

    function automatic logic [45:0] exp_d(longint tc);
        return model(tc, 1024, 24, 136, 160, 768, 3, 6, 29);
    endfunction

    function automatic logic [45:0] exp_s(longint tc);
        return model(tc, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction

    // One clock: advance elapsed time if out of reset, then settle at the falling edge.
    task automatic tick();
        @(posedge clk_in);
        if (!rst) t++;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) tick();
        t = 0;
        tests++;
        if (d_obs !== 46'd0) begin
            fails++;
            $display("FAIL reset_def got=%h exp=%h", d_obs, 46'd0);
        end
        tests++;
        if (s_obs !== 46'd0) begin
            fails++;
            $display("FAIL reset_small got=%h exp=%h", s_obs, 46'd0);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (d_hcount !== 12'd1 || d_vcount !== 12'd0 || d_line_start !== 1'b0 || d_frame_start !== 1'b0) begin
            fails++;
            $display("FAIL first_edge got h=%0d v=%0d ls=%b fs=%b exp h=1 v=0 ls=0 fs=0",
                     d_hcount, d_vcount, d_line_start, d_frame_start);
        end
        $display("[TB] reset: released, first edge h=%0d v=%0d", d_hcount, d_vcount);
    endtask

    // Default build: three full lines checked cycle by cycle, plus per-line flag widths.
    task automatic test_hdecode();
        int hsync_cnt = 0;
        int hblnk_cnt = 0;
        int ls_cnt    = 0;
        int bad       = 0;
        while (t < 3 * 1344 + 5) begin
            tick();
            if (d_vcount == 12'd1) begin
                if (d_hsync) hsync_cnt++;
                if (d_hblnk) hblnk_cnt++;
            end
            if (d_line_start) ls_cnt++;
            if (d_obs !== exp_d(t) && bad < 5) begin
                bad++;
                $display("FAIL hdecode_def t=%0d got=%h exp=%h", t, d_obs, exp_d(t));
            end
            if (s_obs !== exp_s(t) && bad < 5) begin
                bad++;
                $display("FAIL hdecode_small t=%0d got=%h exp=%h", t, s_obs, exp_s(t));
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (hsync_cnt != 136) begin
            fails++;
            $display("FAIL hsync_width got=%0d exp=136", hsync_cnt);
        end
        tests++;
        if (hblnk_cnt != 320) begin
            fails++;
            $display("FAIL hblnk_width got=%0d exp=320", hblnk_cnt);
        end
        tests++;
        if (ls_cnt != 3) begin
            fails++;
            $display("FAIL line_start_count got=%0d exp=3", ls_cnt);
        end
        $display("[TB] hdecode: hsync=%0d hblnk=%0d line_starts=%0d", hsync_cnt, hblnk_cnt, ls_cnt);
    endtask

    // Short build from a fresh reset: vertical decode, frame wraps, frame_count after 294 clocks.
    task automatic test_vdecode();
        int vsync_cnt = 0;
        int vblnk_cnt = 0;
        int bad       = 0;
        rst = 1'b1;
        tick();
        t = 0;
        rst = 1'b0;
        while (t < 294) begin
            tick();
            if (t < 98) begin
                if (s_vsync) vsync_cnt++;
                if (s_vblnk) vblnk_cnt++;
            end
            if (t == 98 || t == 196) begin
                tests++;
                if (s_frame_start !== 1'b1 || s_line_start !== 1'b1 || s_hcount !== 12'd0 ||
                    s_vcount !== 12'd0 || s_frame_count !== 16'(t / 98)) begin
                    fails++;
                    $display("FAIL frame_wrap t=%0d got fs=%b ls=%b h=%0d v=%0d fc=%0d exp fs=1 ls=1 h=0 v=0 fc=%0d",
                             t, s_frame_start, s_line_start, s_hcount, s_vcount, s_frame_count, t / 98);
                end
            end
            if (s_obs !== exp_s(t) && bad < 5) begin
                bad++;
                $display("FAIL vdecode_small t=%0d got=%h exp=%h", t, s_obs, exp_s(t));
            end
            if (d_obs !== exp_d(t) && bad < 5) begin
                bad++;
                $display("FAIL vdecode_def t=%0d got=%h exp=%h", t, d_obs, exp_d(t));
            end
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (vsync_cnt != 14) begin
            fails++;
            $display("FAIL vsync_width got=%0d exp=14", vsync_cnt);
        end
        tests++;
        if (vblnk_cnt != 42) begin
            fails++;
            $display("FAIL vblnk_width got=%0d exp=42", vblnk_cnt);
        end
        tests++;
        if (s_frame_count !== 16'd3) begin
            fails++;
            $display("FAIL frame_count_294 got=%0d exp=3", s_frame_count);
        end
        $display("[TB] vdecode: vsync=%0d vblnk=%0d frame_count=%0d", vsync_cnt, vblnk_cnt, s_frame_count);
    endtask

    // Reset asserted between edges at random points; outputs must clear before
    // the next edge and the run must restart cleanly from the reset state.
    task automatic test_async_reset();
        for (int r = 0; r < 4; r++) begin
            int run_pre  = int'($urandom_range(150, 600));
            int run_post = int'($urandom_range(100, 400));
            int bad      = 0;
            repeat (run_pre) tick();
            #2;
            rst = 1'b1;
            #1;
            tests++;
            if (d_obs !== 46'd0 || s_obs !== 46'd0) begin
                fails++;
                $display("FAIL async_clear round=%0d got def=%h small=%h exp=0", r, d_obs, s_obs);
            end
            repeat (2) tick();
            t = 0;
            rst = 1'b0;
            repeat (run_post) begin
                tick();
                if (d_obs !== exp_d(t) && bad < 3) begin
                    bad++;
                    $display("FAIL restart_def round=%0d t=%0d got=%h exp=%h", r, t, d_obs, exp_d(t));
                end
                if (s_obs !== exp_s(t) && bad < 3) begin
                    bad++;
                    $display("FAIL restart_small round=%0d t=%0d got=%h exp=%h", r, t, s_obs, exp_s(t));
                end
            end
            tests++;
            if (bad != 0) fails++;
            $display("[TB] async_reset round=%0d pre=%0d post=%0d h=%0d fc_small=%0d",
                     r, run_pre, run_post, d_hcount, s_frame_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        t     = 0;
        rst   = 1'b1;
        test_reset();
        test_hdecode();
        test_vdecode();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
